// File: rtl/led_step_ctrl_if.sv
// Key/LED-stepper signal bundle: raw buttons in, registered stepping controls out.
// The controller takes the slave modport and the key driver takes the master modport.
interface led_step_ctrl_if;
  logic [2:0] key_n;
  logic       step;
  logic       dir;
  logic       run;
  logic [1:0] speed;

  modport master (output key_n, input step, dir, run, speed);
  modport slave  (input key_n, output step, dir, run, speed);
endinterface

// File: rtl/led_step_ctrl.sv
// Three debounced push-buttons (speed / run-pause / direction) steering a periodic
// one-cycle step pulse whose period halves with each speed level.
module led_step_ctrl #(
  parameter int DB_CYC      = 1_000_000,
  parameter int BASE_PERIOD = 50_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  led_step_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_e;

  localparam int              DB_W    = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
  localparam logic [27:0]     BASE    = 28'(BASE_PERIOD);

  logic [2:0]      sync1_q, sync2_q;
  db_state_e       state_q  [3];
  db_state_e       state_d  [3];
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [2:0]      press_ev;

  logic [27:0] period, per_cnt_q, per_cnt_d;
  logic [1:0]  speed_q, speed_d;
  logic        run_q, run_d, dir_q, dir_d, step_q, step_d;
  logic        wrap;

  // Released level is 1, so the synchronizer resets high to avoid a phantom press.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM, process 1: state and stable-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k]  <= IDLE;
        db_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k]  <= state_d[k];
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

  // Debounce FSM, process 2: next state. A return from RELEASE_WAIT is bounce, not a press.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_d[k]  = state_q[k];
      db_cnt_d[k] = db_cnt_q[k];
      unique case (state_q[k])
        IDLE: if (!sync2_q[k]) begin
          state_d[k]  = PRESS_WAIT;
          db_cnt_d[k] = '0;
        end
        PRESS_WAIT: begin
          if (sync2_q[k])                 state_d[k]  = IDLE;
          else if (db_cnt_q[k] == DB_LAST) state_d[k]  = PRESSED;
          else                             db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
        PRESSED: if (sync2_q[k]) begin
          state_d[k]  = RELEASE_WAIT;
          db_cnt_d[k] = '0;
        end
        RELEASE_WAIT: begin
          if (!sync2_q[k])                 state_d[k]  = PRESSED;
          else if (db_cnt_q[k] == DB_LAST) state_d[k]  = IDLE;
          else                             db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Debounce FSM, process 3: one press event per accepted press.
  always_comb begin
    for (int k = 0; k < 3; k++)
      press_ev[k] = (state_q[k] == PRESS_WAIT) && (state_d[k] == PRESSED);
  end

  assign period = BASE >> speed_q;
  assign wrap   = run_q && (per_cnt_q == period - 28'd1);

  // A speed change restarts the period and swallows a step due in the same cycle.
  always_comb begin
    per_cnt_d = per_cnt_q;
    step_d    = 1'b0;
    speed_d   = speed_q;
    if (press_ev[0]) begin
      per_cnt_d = '0;
      speed_d   = speed_q + 2'd1;
    end else if (run_q) begin
      if (wrap) begin
        per_cnt_d = '0;
        step_d    = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + 28'd1;
      end
    end
    run_d = run_q ^ press_ev[1];
    dir_d = dir_q ^ press_ev[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      speed_q   <= '0;
      run_q     <= 1'b1;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      speed_q   <= speed_d;
      run_q     <= run_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
    end
  end

  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign bus.run   = run_q;
  assign bus.speed = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl: directed vectors and sequences plus random key traffic,
// all cross-checked every cycle against a run-length behavioural model.
module tb_led_step_ctrl;
  localparam int DB   = 4;
  localparam int BASE = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_step_ctrl_if ifc ();

  led_step_ctrl #(.DB_CYC(DB), .BASE_PERIOD(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a key flips its accepted level once the synchronized input has
  // disagreed with it for DB+1 consecutive samples; a flip to pressed is an event.
  int       m_phase, m_speed;
  bit       m_run, m_dir, m_step;
  bit [2:0] m_s1, m_s2, m_lvl, m_ev;
  int       m_rl [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_speed = 0; m_run = 1; m_dir = 0; m_step = 0;
      m_s1 = '1; m_s2 = '1; m_lvl = '0; m_ev = '0;
      for (int k = 0; k < 3; k++) m_rl[k] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_ev[k] = 1'b0;
        if (!m_s2[k] != m_lvl[k]) begin
          m_rl[k]++;
          if (m_rl[k] == DB + 1) begin
            m_lvl[k] = !m_s2[k];
            m_ev[k]  = m_lvl[k];
            m_rl[k]  = 0;
          end
        end else begin
          m_rl[k] = 0;
        end
      end
      m_step = 0;
      if (m_ev[0]) begin
        m_phase = 0;
        m_speed = (m_speed + 1) % 4;
      end else if (m_run) begin
        if (m_phase == (BASE >> m_speed) - 1) begin
          m_phase = 0;
          m_step  = 1;
        end else begin
          m_phase++;
        end
      end
      if (m_ev[1]) m_run = !m_run;
      if (m_ev[2]) m_dir = !m_dir;
      m_s2 = m_s1;
      m_s1 = ifc.key_n;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("lock_step",  ifc.step,  m_step);
      check("lock_dir",   ifc.dir,   m_dir);
      check("lock_run",   ifc.run,   m_run);
      check("lock_speed", ifc.speed, m_speed);
    end
  end

  // Activity monitor: toggle counts and run-active cycles between consecutive steps.
  int   run_chg = 0, dir_chg = 0, step_cnt = 0, active = 0, last_gap = 0;
  logic run_prev = 1'b1, dir_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      active = 0;
    end else begin
      if (ifc.run !== run_prev) run_chg++;
      if (ifc.dir !== dir_prev) dir_chg++;
      if (ifc.step === 1'b1) begin
        step_cnt++;
        last_gap = active;
        active   = 0;
      end
      if (ifc.run === 1'b1) active++;
    end
    run_prev = ifc.run;
    dir_prev = ifc.dir;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] k, input int hold, input int rel);
    ifc.key_n = k;
    tick(hold);
    ifc.key_n = 3'b111;
    tick(rel);
  endtask

  task automatic wait_step(output int cyc, input int limit);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ifc.step !== 1'b1 && cyc < limit);
    if (ifc.step !== 1'b1) check("step_timeout", 0, 1);
  endtask

  typedef struct {
    logic [2:0] key_n;
    logic [1:0] speed;
    logic       run;
    logic       dir;
  } vec_t;

  vec_t vecs [6];
  int   c, r0, d0, s0;
  int   per_exp [4];
  int   rem [3];
  logic [2:0] kv;

  initial begin
    vecs[0] = '{3'b110, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{3'b110, 2'd2, 1'b1, 1'b0};
    vecs[2] = '{3'b101, 2'd2, 1'b0, 1'b0};
    vecs[3] = '{3'b011, 2'd2, 1'b0, 1'b1};
    vecs[4] = '{3'b000, 2'd3, 1'b1, 1'b0};
    vecs[5] = '{3'b110, 2'd0, 1'b1, 1'b0};
    per_exp = '{8, 4, 2, 16};

    ifc.key_n = 3'b111;
    tick(3);
    check("rst_step",  ifc.step,  0);
    check("rst_speed", ifc.speed, 0);
    check("rst_run",   ifc.run,   1);
    check("rst_dir",   ifc.dir,   0);
    rst_n = 1'b1;

    wait_step(c, 40);
    check("first_step_delay", c, 16);
    for (int i = 0; i < 2; i++) begin
      wait_step(c, 40);
      check("free_period", c, 16);
      check("free_dir", ifc.dir, 0);
    end
    tick(1);
    check("step_width", ifc.step, 0);

    for (int i = 0; i < 6; i++) begin
      press(vecs[i].key_n, 10, 10);
      check($sformatf("vec%0d_speed", i), ifc.speed, vecs[i].speed);
      check($sformatf("vec%0d_run", i),   ifc.run,   vecs[i].run);
      check($sformatf("vec%0d_dir", i),   ifc.dir,   vecs[i].dir);
    end

    for (int i = 0; i < 4; i++) begin
      press(3'b110, 10, 10);
      check($sformatf("speed_lvl%0d", i), ifc.speed, (i + 1) % 4);
      wait_step(c, 64);
      wait_step(c, 64);
      check($sformatf("speed_period%0d", i), c, per_exp[i]);
    end

    wait_step(c, 40);
    #1 r0 = run_chg;
    ifc.key_n = 3'b101; tick(3);
    ifc.key_n = 3'b111; tick(2);
    ifc.key_n = 3'b101; tick(3);
    ifc.key_n = 3'b111; tick(2);
    press(3'b101, 10, 10);
    #1 check("bounce_run_toggles", run_chg - r0, 1);
    check("paused_run", ifc.run, 0);
    s0 = step_cnt;
    tick(50);
    #1 check("paused_no_step", step_cnt - s0, 0);
    press(3'b101, 10, 10);
    check("resumed_run", ifc.run, 1);
    wait_step(c, 40);
    #1 check("resume_held_count", last_gap, 16);

    wait_step(c, 40);
    tick(9);
    ifc.key_n = 3'b110;
    wait_step(c, 40);
    check("speed_at_wrap_next_step", c, 15);
    check("speed_at_wrap_level", ifc.speed, 1);
    ifc.key_n = 3'b111;
    tick(10);

    #1 d0 = dir_chg;
    ifc.key_n = 3'b011;
    tick(1000);
    #1 check("dir_hold_toggles", dir_chg - d0, 1);
    check("dir_hold_value", ifc.dir, 1);
    ifc.key_n = 3'b111;
    tick(10);
    press(3'b011, 10, 10);
    check("dir_back", ifc.dir, 0);

    ifc.key_n = 3'b110;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("midrst_step",  ifc.step,  0);
    check("midrst_speed", ifc.speed, 0);
    check("midrst_run",   ifc.run,   1);
    check("midrst_dir",   ifc.dir,   0);
    ifc.key_n = 3'b111;
    tick(3);
    rst_n = 1'b1;
    wait_step(c, 40);
    check("midrst_first_step", c, 16);
    check("midrst_speed_after", ifc.speed, 0);

    kv = 3'b111;
    for (int k = 0; k < 3; k++) rem[k] = $urandom_range(1, 12);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          kv[k]  = ~kv[k];
          rem[k] = $urandom_range(1, 12);
        end else begin
          rem[k]--;
        end
      end
      ifc.key_n = kv;
      tick(1);
    end
    ifc.key_n = 3'b111;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_step_ctrl.md
LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 Parameter DB_CYC, default 1_000_000, sets the number of consecutive stable sampled cycles needed to accept a key edge (20 ms at 50 MHz).
REQ-002 Parameter BASE_PERIOD, default 50_000_000, sets the step period in clk cycles at speed level 0.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_n  input  3  raw asynchronous push-buttons, active low; bit0 = speed, bit1 = run/pause, bit2 = direction.
REQ-006 step  output  1  one-cycle pulse per LED advance, consumed by the downstream LED shifter.
REQ-007 dir  output  1  shift direction; 0 = toward MSB, 1 = toward LSB.
REQ-008 run  output  1  1 = stepping enabled, 0 = paused.
REQ-009 speed  output  2  current speed level, 0..3.

Function
REQ-010 Each key_n bit shall pass through a 2-flop synchronizer before any other use.
REQ-011 Each key shall have an independent debounce FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when the synchronized key reads 0; the per-key stable counter is cleared.
REQ-013 PRESS_WAIT -> IDLE if the key reads 1 before the counter reaches DB_CYC-1; -> PRESSED when the counter reaches DB_CYC-1 with the key still 0.
REQ-014 The transition into PRESSED shall produce exactly one internal one-cycle press event.
REQ-015 PRESSED -> RELEASE_WAIT when the key reads 1; RELEASE_WAIT -> PRESSED if the key reads 0 before DB_CYC-1; -> IDLE after DB_CYC-1 stable cycles at 1.
REQ-016 Holding a key indefinitely shall generate no further events.
REQ-017 Speed event: speed increments modulo 4 (3 -> 0).
REQ-018 Run event: run toggles.
REQ-019 Direction event: dir toggles.
REQ-020 Step period shall be BASE_PERIOD >> speed.
REQ-021 The period counter shall be 28 bits wide.
REQ-022 While run=1, the period counter increments each cycle; when it equals period-1, it wraps to 0 and step=1 for that one cycle.
REQ-023 While run=0, the period counter holds its value, step=0, and resuming continues from the held count.
REQ-024 A speed event shall clear the period counter to 0 in the same cycle and suppress any step that would otherwise fire in that cycle.
REQ-025 Run and direction events coinciding with a wrap shall not suppress that step; the new dir value is visible from the next cycle.
REQ-026 Events from different keys in the same cycle shall all take effect.
REQ-027 step, dir, run and speed shall all be registered outputs.

Reset
REQ-028 While rst_n=0: speed=0, run=1, dir=0, step=0, period counter=0, all FSMs in IDLE, synchronizers at 1 (keys released).
REQ-029 Reset asserted mid-debounce or mid-period shall abandon the operation and produce no event or step on release.
REQ-030 After rst_n deasserts, the first step shall occur BASE_PERIOD cycles later, provided no key is active.

Verification (DB_CYC=4, BASE_PERIOD=16)
REQ-031 No keys pressed, run from reset -> step pulses exactly every 16 cycles, each 1 cycle wide, dir=0.
REQ-032 key_n[0] held low for 10 cycles, three times -> speed goes 1, 2, 3 and step period becomes 8, 4, 2; a fourth press -> speed=0, period 16.
REQ-033 key_n[1] bounces 0/1/0 with each level shorter than 4 cycles, then held low 10 cycles -> exactly one toggle, run=0, no step while paused; second clean press -> run=1 and stepping resumes from the held count.
REQ-034 Speed press accepted in the same cycle the counter reaches 15 -> no step in that cycle; the next step comes 8 cycles later.
REQ-035 key_n[2] held low for 1000 cycles -> dir toggles exactly once; after release plus a new press -> dir toggles back to 0.
REQ-036 rst_n pulsed low mid-debounce of key_n[0] and mid-period -> outputs return to reset values and no speed change is seen after reset.
